// File: rtl/vga_frame_mem.sv
// 1-bit-per-pixel frame buffer: read-modify-write plotting on the write side and a
// 2-cycle registered colour read port; a sequenced clear engine runs after reset and on request.
module vga_frame_mem #(
  parameter int         MEM_WIDTH_X = 128,
  parameter int         MEM_WIDTH_Y = 128,
  parameter int         WORD_BITS   = 32,
  parameter logic [7:0] FG_COLOR    = 8'hFF,
  parameter logic [7:0] BG_COLOR    = 8'h00,
  localparam int        XW          = $clog2(MEM_WIDTH_X),
  localparam int        YW          = $clog2(MEM_WIDTH_Y)
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iClear,
  input  logic          iValid,
  input  logic [XW-1:0] iXm,
  input  logic [YW-1:0] iYm,
  output logic          oReady,
  output logic          oBusy,
  output logic          oDrop,
  input  logic [XW-1:0] iVideoMemX,
  input  logic [YW-1:0] iVideoMemY,
  output logic [2:0]    oVGARed,
  output logic [2:0]    oVGAGreen,
  output logic [1:0]    oVGABlue
);

  localparam int DEPTH = MEM_WIDTH_X * MEM_WIDTH_Y / WORD_BITS;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(WORD_BITS);
  localparam int LW    = XW + YW;
  localparam logic [XW:0] XLIM = (XW+1)'(MEM_WIDTH_X);
  localparam logic [YW:0] YLIM = (YW+1)'(MEM_WIDTH_Y);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_PLOT_RD, S_PLOT_WR} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [WORD_BITS-1:0] rmw_q;
  logic [WORD_BITS-1:0] rd_word_q;
  logic                 rd_ok_q;
  logic [BW-1:0]        rd_bit_q;
  logic [7:0]           color_q;

  logic [WORD_BITS-1:0] mem [DEPTH];

  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;
  logic [WORD_BITS-1:0] mem_wdata;

  function automatic logic [LW-1:0] lin_of(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return LW'(y) * LW'(MEM_WIDTH_X) + LW'(x);
  endfunction

  logic          wr_in_range, rd_in_range;
  logic [LW-1:0] wr_lin, rd_lin;
  logic [AW-1:0] rd_addr;

  always_comb begin
    wr_in_range = ({1'b0, iXm} < XLIM) && ({1'b0, iYm} < YLIM);
    rd_in_range = ({1'b0, iVideoMemX} < XLIM) && ({1'b0, iVideoMemY} < YLIM);
    wr_lin      = lin_of(iXm, iYm);
    rd_lin      = lin_of(iVideoMemX, iVideoMemY);
    // Out-of-range reads are steered to word 0 so the array is never indexed past DEPTH.
    rd_addr     = rd_in_range ? AW'(rd_lin >> BW) : '0;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state_q <= S_CLEAR;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR:   if (cnt_q == AW'(DEPTH-1)) state_d = S_IDLE;
      S_IDLE: begin
        if (iClear)                     state_d = S_CLEAR;
        else if (iValid && wr_in_range) state_d = S_PLOT_RD;
      end
      S_PLOT_RD: state_d = S_PLOT_WR;
      S_PLOT_WR: state_d = S_IDLE;
      default:   state_d = S_CLEAR;
    endcase
  end

  always_comb begin
    oReady    = (state_q == S_IDLE) && !iClear;
    oBusy     = (state_q == S_CLEAR);
    oDrop     = (state_q == S_IDLE) && !iClear && iValid && !wr_in_range;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = '0;
    if (state_q == S_CLEAR) begin
      mem_we = 1'b1;
    end else if (state_q == S_PLOT_WR) begin
      mem_we    = 1'b1;
      mem_waddr = addr_q;
      mem_wdata = rmw_q | (WORD_BITS'(1) << bit_q);
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    bit_d  = bit_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + AW'(1);
    end else if (state_q == S_IDLE) begin
      if (iClear) begin
        cnt_d = '0;
      end else if (iValid && wr_in_range) begin
        addr_d = AW'(wr_lin >> BW);
        bit_d  = wr_lin[BW-1:0];
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q    <= '0;
      addr_q   <= '0;
      bit_q    <= '0;
      rd_ok_q  <= 1'b0;
      rd_bit_q <= '0;
      color_q  <= BG_COLOR;
    end else begin
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      bit_q    <= bit_d;
      rd_ok_q  <= rd_in_range && (state_q != S_CLEAR);
      rd_bit_q <= rd_lin[BW-1:0];
      color_q  <= (rd_ok_q && rd_word_q[rd_bit_q]) ? FG_COLOR : BG_COLOR;
    end
  end

  // Array storage carries no reset; the clear engine owns initialisation.
  always_ff @(posedge iClk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (state_q == S_PLOT_RD) rmw_q <= mem[addr_q];
    rd_word_q <= mem[rd_addr];
  end

  assign oVGARed   = color_q[7:5];
  assign oVGAGreen = color_q[4:2];
  assign oVGABlue  = color_q[1:0];

endmodule

// File: tb/tb_vga_frame_mem.sv
// Scoreboard bench: default 128x128 instance plus a 100x60 instance, checked against a per-pixel model.
module tb_vga_frame_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       clr0 = 1'b0, clr1 = 1'b0, valid0 = 1'b0, valid1 = 1'b0;
  logic [6:0] xm0 = '0, ym0 = '0, rx0 = '0, ry0 = '0;
  logic [6:0] xm1 = '0, rx1 = '0;
  logic [5:0] ym1 = '0, ry1 = '0;
  logic       ready [2];
  logic       busy  [2];
  logic       drop  [2];
  logic [2:0] red   [2];
  logic [2:0] green [2];
  logic [1:0] blue  [2];

  vga_frame_mem u0 (
    .iClk(clk), .iRst_n(rst_n), .iClear(clr0), .iValid(valid0), .iXm(xm0), .iYm(ym0),
    .oReady(ready[0]), .oBusy(busy[0]), .oDrop(drop[0]),
    .iVideoMemX(rx0), .iVideoMemY(ry0),
    .oVGARed(red[0]), .oVGAGreen(green[0]), .oVGABlue(blue[0]));

  vga_frame_mem #(.MEM_WIDTH_X(100), .MEM_WIDTH_Y(60), .WORD_BITS(16)) u1 (
    .iClk(clk), .iRst_n(rst_n), .iClear(clr1), .iValid(valid1), .iXm(xm1), .iYm(ym1),
    .oReady(ready[1]), .oBusy(busy[1]), .oDrop(drop[1]),
    .iVideoMemX(rx1), .iVideoMemY(ry1),
    .oVGARed(red[1]), .oVGAGreen(green[1]), .oVGABlue(blue[1]));

  int W [2] = '{128, 100};
  int H [2] = '{128, 60};
  bit px [2][128][128];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int passed = 0, total = 0;
  int cyc = 0;
  bit rq [2] = '{0, 0};
  bit s1 [2] = '{0, 0};
  bit s2 [2] = '{0, 0};
  int lx [2][64];
  int ly [2][64];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] ref_col(input int i, input int x, input int y);
    if (x >= W[i] || y >= H[i]) return 8'h00;
    return px[i][x][y] ? 8'hFF : 8'h00;
  endfunction

  function automatic void clear_model(input int i);
    for (int x = 0; x < 128; x++)
      for (int y = 0; y < 128; y++) px[i][x][y] = 1'b0;
  endfunction

  // Read-return pipeline tracks which cycles carry a colour that the bench asked for.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      s1[i] <= rq[i];
      s2[i] <= s1[i];
    end
  end

  task automatic pop_chk(input int i);
    logic [7:0] e;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      chk("sb_underflow", 1, 0);
    end else begin
      e = (i == 0) ? q0.pop_front() : q1.pop_front();
      chk(i == 0 ? "rd_col0" : "rd_col1", {red[i], green[i], blue[i]}, e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (s2[0]) pop_chk(0);
    if (s2[1]) pop_chk(1);
  end

  task automatic set_wr(input int i, input bit v, input int x, input int y);
    if (i == 0) begin valid0 = v; xm0 = x[6:0]; ym0 = y[6:0]; end
    else        begin valid1 = v; xm1 = x[6:0]; ym1 = y[5:0]; end
  endtask

  task automatic rd(input int i, input int x, input int y, input bit force_bg);
    logic [7:0] e;
    e = force_bg ? 8'h00 : ref_col(i, x, y);
    if (i == 0) begin q0.push_back(e); rx0 = x[6:0]; ry0 = y[6:0]; end
    else        begin q1.push_back(e); rx1 = x[6:0]; ry1 = y[5:0]; end
    rq[i] = 1'b1;
    @(posedge clk); #1;
    rq[i] = 1'b0;
  endtask

  task automatic wr(input int i, input int x, input int y, output int acc);
    int n;
    bit oor;
    oor = (x >= W[i]) || (y >= H[i]);
    acc = -1;
    n = 0;
    set_wr(i, 1'b1, x, y);
    forever begin
      @(negedge clk);
      if (ready[i] || n > 20) break;
      n++;
    end
    if (!ready[i]) begin
      chk("wr_timeout", 0, 1);
    end else begin
      chk("drop", int'(drop[i]), int'(oor));
      acc = cyc;
      if (!oor) px[i][x][y] = 1'b1;
    end
    @(posedge clk); #1;
    set_wr(i, 1'b0, x, y);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic measure_clear(output int n0, output int n1);
    int n;
    n = 0; n0 = -1; n1 = -1;
    while ((n0 < 0 || n1 < 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (n0 < 0 && !busy[0]) n0 = n;
      if (n1 < 0 && !busy[1]) n1 = n;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int a, b, c, n0, n1, c0, n, x, y, k;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", int'(busy[i]), 1);
      chk("rst_ready", int'(ready[i]), 0);
      chk("rst_drop", int'(drop[i]), 0);
      chk("rst_col", int'({red[i], green[i], blue[i]}), 0);
    end

    @(negedge clk) rst_n = 1'b1;
    measure_clear(n0, n1);
    chk("clear_len0", n0, 512);
    chk("clear_len1", n1, 375);
    chk("ready_after_clear", int'(ready[0]), 1);

    rd(0, 0, 0, 0); rd(0, 127, 127, 0); rd(0, 64, 3, 0);

    wr(0, 5, 2, a);
    settle();
    rd(0, 5, 2, 0); rd(0, 4, 2, 0); rd(0, 6, 2, 0); rd(0, 5, 1, 0);

    wr(0, 0, 0, a); wr(0, 31, 0, b); wr(0, 32, 0, c);
    chk("b2b_gap1", b - a, 3);
    chk("b2b_gap2", c - b, 3);
    settle();
    rd(0, 0, 0, 0); rd(0, 31, 0, 0); rd(0, 32, 0, 0); rd(0, 1, 0, 0); rd(0, 33, 0, 0);

    wr(1, 100, 10, a);
    wr(1, 99, 59, a);
    settle();
    rd(1, 99, 59, 0); rd(1, 100, 10, 0); rd(1, 0, 11, 0); rd(1, 99, 60, 0);

    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 40; j++) begin
        x = $urandom_range(127);
        y = (i == 0) ? $urandom_range(127) : $urandom_range(63);
        lx[i][j] = x; ly[i][j] = y;
        wr(i, x, y, a);
      end
    end
    settle();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 50; j++) begin
        if ($urandom_range(1) == 1) begin
          k = $urandom_range(39);
          x = lx[i][k]; y = ly[i][k];
        end else begin
          x = $urandom_range(127);
          y = (i == 0) ? $urandom_range(127) : $urandom_range(63);
        end
        rd(i, x, y, 0);
      end
    end

    // A clear request while a plot is in flight is dropped and the plot lands.
    wr(0, 20, 20, a);
    clr0 = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    clr0 = 1'b0;
    chk("clr_ignored_busy", int'(busy[0]), 0);
    settle();
    rd(0, 20, 20, 0);

    wr(0, 127, 127, a);
    settle();
    clr0 = 1'b1;
    set_wr(0, 1'b1, 10, 10);
    @(negedge clk);
    chk("clr_vs_wr_ready", int'(ready[0]), 0);
    chk("clr_vs_wr_drop", int'(drop[0]), 0);
    @(posedge clk); #1;
    clr0 = 1'b0;
    set_wr(0, 1'b0, 10, 10);
    c0 = cyc;
    chk("clr_busy", int'(busy[0]), 1);
    rd(0, 127, 127, 1); rd(0, 5, 2, 1);
    n = 0;
    while (busy[0] && n < 3000) begin @(posedge clk); #1; n++; end
    chk("clr_req_len", cyc - c0, 512);
    clear_model(0);
    rd(0, 127, 127, 0); rd(0, 20, 20, 0); rd(0, 10, 10, 0); rd(0, 5, 2, 0);

    wr(0, 7, 7, a);
    settle();
    rx0 = 7'd7; ry0 = 7'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_col", int'({red[0], green[0], blue[0]}), 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_col", int'({red[0], green[0], blue[0]}), 0);
    chk("async_rst_busy", int'(busy[0]), 1);
    chk("async_rst_ready", int'(ready[0]), 0);
    clear_model(0); clear_model(1);
    @(negedge clk) rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("mid_clear_busy", int'(busy[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_clear_rst_busy", int'(busy[0]), 1);
    chk("mid_clear_rst_ready", int'(ready[0]), 0);
    @(negedge clk) rst_n = 1'b1;
    measure_clear(n0, n1);
    chk("reclear_len0", n0, 512);
    chk("reclear_len1", n1, 375);
    rd(0, 7, 7, 0); rd(1, 99, 59, 0);

    repeat (5) @(posedge clk);
    #2;
    chk("sb_empty0", q0.size(), 0);
    chk("sb_empty1", q1.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
